// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer.
//   - ALU opcode encodings (OP_NOOP .. OP_RESET)
//   - default operand/result width
//   - sequencer FSM state encoding
//   - fill bit for the rejected-command result (all ones)
package alu_pkg;

    localparam int W_DEFAULT = 16;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_MULT  = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_NOT   = 4'd8;
    localparam logic [3:0] OP_RESET = 4'd15;

    // Rejected commands report a result of all ones.
    localparam logic ERR_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    // Opcodes 9..14 have no ALU operation behind them.
    function automatic logic op_illegal(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO, DEPTH entries of DW bits.
// No fall-through: a written entry is visible on dout from the next cycle.
// A push while full is dropped (full is the registered state at cycle start,
// so a same-cycle pop does not make room). A pop while empty is ignored.
// Ports:
//   clk, clear_n     clock, asynchronous active-low reset
//   push, din        write request and data
//   pop, dout        read request and head-of-queue data
//   full, empty      occupancy flags
module alu_cmd_fifo #(
    parameter int DW    = 37,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_q];

    // Pointers wrap naturally since DEPTH is a power of two; the count
    // separates full from empty when the pointers are equal.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end for the accumulator ALU.
// Buffers commands in alu_cmd_fifo, screens illegal opcodes and divide by
// zero, drives the ALU one op at a time and returns each result with an
// error flag on a valid/ready channel.
// Ports:
//   clk, clear_n                       clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_opcode,
//   cmd_a, cmd_b, cmd_chain            command channel (chain: A := acc)
//   alu_opcode, alu_input1/2           registered ALU drive
//   alu_result                         ALU combinational result
//   res_valid/ready, res_data,
//   res_err, res_opcode                result channel
//   busy                               FIFO non-empty or FSM not idle
// Optional: define ALU_SEQ_STATS_EN to add stat_ops / stat_errs, saturating
// counters of result handshakes and of errored result handshakes.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_opcode,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_chain,
    output logic [3:0]   alu_opcode,
    output logic [W-1:0] alu_input1,
    output logic [W-1:0] alu_input2,
    input  logic [W-1:0] alu_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic [3:0]   res_opcode,
    output logic         busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]  stat_ops,
    output logic [15:0]  stat_errs
`endif
);

    typedef struct packed {
        logic         chain;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } cmd_t;

    cmd_t       push_cmd, head;
    logic       fifo_full, fifo_empty, fifo_pop;
    seq_state_e state_q, state_d;

    logic [W-1:0] acc_q, acc_d;
    logic [3:0]   alu_op_q, alu_op_d;
    logic [W-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
    logic [3:0]   exec_op_q, exec_op_d;
    logic         exec_err_q, exec_err_d;
    logic         res_valid_q, res_valid_d;
    logic [W-1:0] res_data_q, res_data_d;
    logic         res_err_q, res_err_d;
    logic [3:0]   res_op_q, res_op_d;

    logic         ld_err;
    logic [W-1:0] ld_a, exec_res;

    assign push_cmd = '{chain: cmd_chain, op: cmd_opcode, a: cmd_a, b: cmd_b};

    alu_cmd_fifo #(.DW($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .clear_n (clear_n),
        .push    (cmd_valid),
        .din     (push_cmd),
        .pop     (fifo_pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Decode of the head entry, used whenever it is popped.
    assign ld_err   = op_illegal(head.op) || ((head.op == OP_DIV) && (head.b == '0));
    assign ld_a     = head.chain ? acc_q : head.a;
    // RESET clears the accumulator regardless of what the ALU reports.
    assign exec_res = (exec_op_q == OP_RESET) ? '0 : alu_result;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        alu_op_d    = alu_op_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        exec_op_d   = exec_op_q;
        exec_err_d  = exec_err_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        res_op_d    = res_op_q;
        fifo_pop    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d     = ST_RESP;
                res_valid_d = 1'b1;
                res_op_d    = exec_op_q;
                alu_op_d    = OP_NOOP;
                if (exec_err_q) begin
                    res_data_d = {W{ERR_FILL}};
                    res_err_d  = 1'b1;
                end else begin
                    res_data_d = exec_res;
                    res_err_d  = 1'b0;
                    acc_d      = exec_res;
                end
            end
            ST_RESP: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_EXEC;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Rejected commands never reach the ALU: it sees NOOP with zero inputs.
        if (fifo_pop) begin
            exec_op_d  = head.op;
            exec_err_d = ld_err;
            alu_op_d   = ld_err ? OP_NOOP : head.op;
            alu_in1_d  = ld_err ? '0 : ld_a;
            alu_in2_d  = ld_err ? '0 : head.b;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            alu_op_q    <= OP_NOOP;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            exec_op_q   <= OP_NOOP;
            exec_err_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_op_q    <= OP_NOOP;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            alu_op_q    <= alu_op_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            exec_op_q   <= exec_op_d;
            exec_err_q  <= exec_err_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            res_op_q    <= res_op_d;
        end
    end

    assign cmd_ready  = ~fifo_full;
    assign alu_opcode = alu_op_q;
    assign alu_input1 = alu_in1_q;
    assign alu_input2 = alu_in2_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign res_opcode = res_op_q;
    assign busy       = ~fifo_empty | (state_q != ST_IDLE);

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops_q, stat_errs_q;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            stat_ops_q  <= '0;
            stat_errs_q <= '0;
        end else if (res_valid_q && res_ready) begin
            if (stat_ops_q != 16'hFFFF)               stat_ops_q  <= stat_ops_q + 16'd1;
            if (res_err_q && stat_errs_q != 16'hFFFF) stat_errs_q <= stat_errs_q + 16'd1;
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer.
// Contains a small accumulator-ALU environment model answering alu_result,
// a queue-based reference model of the expected result stream, directed
// scenarios with literal expectations, and a randomized phase with random
// result backpressure.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         clear_n, cmd_valid, cmd_ready, cmd_chain;
    logic         res_valid, res_ready, res_err, busy;
    logic [3:0]   cmd_opcode, alu_opcode, res_opcode;
    logic [W-1:0] cmd_a, cmd_b, alu_input1, alu_input2, alu_result, res_data;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0]  stat_ops, stat_errs;
`endif

    always #5 clk = ~clk;

    alu_op_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_chain  (cmd_chain),
        .alu_opcode (alu_opcode),
        .alu_input1 (alu_input1),
        .alu_input2 (alu_input2),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .res_opcode (res_opcode),
        .busy       (busy)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_errs  (stat_errs)
`endif
    );

    // ---------------- environment: accumulator ALU ----------------
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] x,
                                           input logic [15:0] y, input logic [15:0] hold);
        case (op)
            4'd1:    return x + y;
            4'd2:    return x - y;
            4'd3:    return x * y;
            4'd4:    return (y == 16'd0) ? 16'hFFFF : x / y;
            4'd5:    return x & y;
            4'd6:    return x | y;
            4'd7:    return x ^ y;
            4'd8:    return ~x;
            4'd15:   return 16'd0;
            default: return hold;
        endcase
    endfunction

    logic [15:0] alu_hold;
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n)                alu_hold <= 16'd0;
        else if (alu_opcode != 4'd0) alu_hold <= alu_result;
    end
    assign alu_result = alu_fn(alu_opcode, alu_input1, alu_input2, alu_hold);

    // ---------------- reference model + bookkeeping ----------------
    typedef struct {
        logic [3:0]  cop;
        logic        err;
        logic [15:0] in1, in2, data;
    } exp_t;

    exp_t        q[$];
    logic [15:0] macc, last_data, last_in1;
    logic        last_err;
    int          errors, checks, cyc, n_hs, n_err_hs, alu_act;
    int          hs_cyc[$];
    bit          rand_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic ch);
        exp_t e;
        e.cop = op;
        e.in1 = ch ? macc : a;
        e.in2 = b;
        e.err = (op >= 4'd9 && op <= 4'd14) || (op == 4'd4 && b == 16'd0);
        if (e.err) begin
            e.data = 16'hFFFF;
        end else begin
            e.data = alu_fn(op, e.in1, b, macc);
            macc   = e.data;
        end
        q.push_back(e);
    endtask

    // Observes DUT at negedge: what is seen here happens at the next posedge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (clear_n) begin
                if (alu_opcode != 4'd0) begin
                    alu_act++;
                    last_in1 = alu_input1;
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL alu_drive: got op %0h expected no drive", alu_opcode);
                    end else begin
                        chk("alu_opcode", 32'(alu_opcode), q[0].err ? 32'd0 : 32'(q[0].cop));
                        chk("alu_input1", 32'(alu_input1), 32'(q[0].in1));
                        chk("alu_input2", 32'(alu_input2), 32'(q[0].in2));
                    end
                end
                if (res_valid && res_ready) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL res_unexpected: got data %0h expected no result", res_data);
                    end else begin
                        e = q.pop_front();
                        chk("res_data",   32'(res_data),   32'(e.data));
                        chk("res_err",    32'(res_err),    32'(e.err));
                        chk("res_opcode", 32'(res_opcode), 32'(e.cop));
                    end
                    last_data = res_data;
                    last_err  = res_err;
                    hs_cyc.push_back(cyc);
                    n_hs++;
                    if (res_err) n_err_hs++;
                end
                if (cmd_valid && cmd_ready) model_accept(cmd_opcode, cmd_a, cmd_b, cmd_chain);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic ch);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_chain = ch;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: got cmd_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || res_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy %0b expected 0 within 500 cycles", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_assert();
        clear_n  = 1'b0;
        q.delete();
        macc     = 16'd0;
        n_hs     = 0;
        n_err_hs = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int a0;
        errors = 0; checks = 0; cyc = 0; alu_act = 0; rand_done = 0;
        last_data = '0; last_in1 = '0; last_err = 1'b0;
        cmd_valid = 0; cmd_opcode = 0; cmd_a = 0; cmd_b = 0; cmd_chain = 0;
        res_ready = 1'b1;
        reset_assert();
        fork monitor(); join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid",  32'(res_valid),  0);
        chk("rst_busy",       32'(busy),       0);
        chk("rst_alu_opcode", 32'(alu_opcode), 0);
        chk("rst_alu_input1", 32'(alu_input1), 0);
        chk("rst_res_data",   32'(res_data),   0);
        chk("rst_res_err",    32'(res_err),    0);
        chk("rst_res_opcode", 32'(res_opcode), 0);
        clear_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);

        // Single ADD with latency
        send(OP_ADD, 16'd1, 16'd1, 1'b0);
        @(negedge clk);
        chk("lat_e0_valid", 32'(res_valid), 0);
        @(negedge clk);
        chk("lat_e1_alu_op", 32'(alu_opcode), 1);
        chk("lat_e1_in1",    32'(alu_input1), 1);
        chk("lat_e1_valid",  32'(res_valid),  0);
        @(negedge clk);
        chk("lat_e2_valid",  32'(res_valid),  1);
        chk("lat_e2_data",   32'(res_data),   2);
        chk("lat_e2_err",    32'(res_err),    0);
        chk("lat_e2_op",     32'(res_opcode), 1);
        wait_idle();

        // Chain: SUB 3-1 = 2, then MULT acc*3 = 6
        send(OP_SUB, 16'd3, 16'd1, 1'b0);
        send(OP_MULT, 16'd0, 16'd3, 1'b1);
        wait_idle();
        chk("chain_in1",  32'(last_in1),  2);
        chk("chain_data", 32'(last_data), 6);

        // Divide by zero rejected, acc untouched
        a0 = alu_act;
        send(OP_DIV, 16'd8, 16'd0, 1'b0);
        wait_idle();
        chk("div0_no_drive", 32'(alu_act),   32'(a0));
        chk("div0_data",     32'(last_data), 32'hFFFF);
        chk("div0_err",      32'(last_err),  1);
        send(OP_ADD, 16'd0, 16'd0, 1'b1);
        wait_idle();
        chk("div0_acc_kept", 32'(last_data), 6);
        send(OP_DIV, 16'd8, 16'd2, 1'b0);
        wait_idle();
        chk("div_data", 32'(last_data), 4);

        // Illegal opcode then AND
        send(4'b1010, 16'd1, 16'd2, 1'b0);
        wait_idle();
        chk("illegal_err", 32'(last_err), 1);
        send(OP_AND, 16'd15, 16'd9, 1'b0);
        wait_idle();
        chk("and_data", 32'(last_data), 9);
        chk("and_err",  32'(last_err),  0);

        // Backpressure: 1 in RESP + 4 in FIFO, 6th refused, ordered drain
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(OP_ADD, 16'(i), 16'd1, 1'b0);
        @(negedge clk);
        chk("bp_full_ready", 32'(cmd_ready), 0);
        chk("bp_busy",       32'(busy),      1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = OP_XOR; cmd_a = 16'h1234; cmd_b = 16'h00FF; cmd_chain = 0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_6th_refused", 32'(cmd_ready), 0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        hs_cyc.delete();
        res_ready = 1'b1;
        wait_idle();
        chk("bp_drain_count", 32'(hs_cyc.size()), 5);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("bp_drain_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 2);
        chk("bp_last_data", 32'(last_data), 6);

        // Reset while in EXEC
        send(OP_ADD, 16'd5, 16'd5, 1'b0);
        @(posedge clk); #1;
        chk("rexec_pre_op", 32'(alu_opcode), 1);
        reset_assert();
        #1;
        chk("rexec_valid",  32'(res_valid),  0);
        chk("rexec_busy",   32'(busy),       0);
        chk("rexec_alu_op", 32'(alu_opcode), 0);
        @(posedge clk); #1;
        clear_n = 1'b1;
        @(negedge clk);
        chk("rexec_ready", 32'(cmd_ready), 1);
        chk("rexec_empty", 32'(busy),      0);
        send(OP_ADD, 16'd3, 16'd4, 1'b0);
        send(OP_RESET, 16'd9, 16'd9, 1'b0);
        wait_idle();
        chk("reset_op_data", 32'(last_data), 0);
        send(OP_ADD, 16'h7777, 16'd5, 1'b1);
        wait_idle();
        chk("reset_acc_zero", 32'(last_data), 5);

        // Randomized traffic with random result backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [3:0]  op;
                    logic [15:0] a, b;
                    op = 4'($urandom_range(0, 15));
                    a  = 16'($urandom);
                    b  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(op, a, b, ($urandom_range(0, 2) == 0));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        res_ready = 1'b1;
        wait_idle();
        chk("rand_queue_drained", 32'(q.size()), 0);
`ifdef ALU_SEQ_STATS_EN
        chk("stat_ops",  32'(stat_ops),  32'(n_hs));
        chk("stat_errs", 32'(stat_errs), 32'(n_err_hs));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
